// File: rtl/seven_segment_decoder.sv
// Deglitches an 8-bit segment bus and decodes each newly stable glyph to BCD, checking digit/dp sequencing.
// Latency: results appear STABLE_CYCLES edges after seg_in settles. There is no backpressure; results are one-cycle pulses.
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit CHECK_SEQ     = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [7:0]       seg_in,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    output logic             pattern_err,
    output logic             seq_err,
    output logic             dp_err,
    output logic [CNT_W-1:0] digit_count,
    output logic [7:0]       err_count
);

    localparam int RUN_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [7:0]       sample_q;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             restart;
    logic             accept_now;
    logic             accept_q;
    logic [7:0]       glyph_q;
    logic [3:0]       prev_code;
    logic             prev_dp;
    logic             have_prev;

    logic [3:0]       code;
    logic [3:0]       expect_code;
    logic             code_legal;
    logic             seq_hit;
    logic             dp_hit;
    logic             pat_hit;

    function automatic logic [3:0] decode(input logic [6:0] segs);
        logic [3:0] c;
        case (segs)
            7'h3F:   c = 4'd0;
            7'h06:   c = 4'd1;
            7'h5B:   c = 4'd2;
            7'h4F:   c = 4'd3;
            7'h66:   c = 4'd4;
            7'h6D:   c = 4'd5;
            7'h7D:   c = 4'd6;
            7'h07:   c = 4'd7;
            7'h7F:   c = 4'd8;
            7'h6F:   c = 4'd9;
            7'h79:   c = 4'hE;
            default: c = 4'hF;
        endcase
        return c;
    endfunction

    // A run fires only on the edge it reaches RUN_MAX, so a held glyph is accepted once.
    always_comb begin
        restart    = (seg_in != sample_q);
        run_next   = run_cnt;
        accept_now = 1'b0;
        if (restart) begin
            run_next = RUN_ONE;
        end else if (run_cnt != RUN_MAX) begin
            run_next = run_cnt + RUN_ONE;
        end
        accept_now = (run_next == RUN_MAX) && (restart || (run_cnt != RUN_MAX));
    end

    always_comb begin
        code        = decode(glyph_q[6:0]);
        code_legal  = (code <= 4'd9);
        expect_code = (prev_code == 4'd9) ? 4'd0 : prev_code + 4'd1;
        pat_hit     = (code == 4'hF);
        seq_hit     = CHECK_SEQ && have_prev && (prev_code <= 4'd9) && code_legal &&
                      (code != expect_code);
        dp_hit      = have_prev && (glyph_q[7] == prev_dp);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sample_q    <= 8'h00;
            run_cnt     <= '0;
            accept_q    <= 1'b0;
            glyph_q     <= 8'h00;
            prev_code   <= 4'd0;
            prev_dp     <= 1'b0;
            have_prev   <= 1'b0;
            digit_out   <= 4'd0;
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            dp_err      <= 1'b0;
            digit_count <= '0;
            err_count   <= 8'd0;
        end else begin
            sample_q    <= seg_in;
            run_cnt     <= run_next;
            accept_q    <= accept_now;
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            dp_err      <= 1'b0;
            if (accept_now) begin
                glyph_q <= seg_in;
            end
            if (accept_q) begin
                digit_out   <= code;
                digit_valid <= 1'b1;
                pattern_err <= pat_hit;
                seq_err     <= seq_hit;
                dp_err      <= dp_hit;
                prev_code   <= code;
                prev_dp     <= glyph_q[7];
                have_prev   <= 1'b1;
                if (code_legal && (digit_count != {CNT_W{1'b1}})) begin
                    digit_count <= digit_count + 1'b1;
                end
                if ((pat_hit || seq_hit || dp_hit) && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed and random glyph streams checked against a window-based reference model.
module tb_seven_segment_decoder;

    localparam int S = 4;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  seg_in = 8'h00;
    logic [3:0]  digit_out;
    logic        digit_valid;
    logic        pattern_err;
    logic        seq_err;
    logic        dp_err;
    logic [15:0] digit_count;
    logic [7:0]  err_count;

    seven_segment_decoder #(.STABLE_CYCLES(S), .CHECK_SEQ(1'b1), .CNT_W(16)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .seg_in      (seg_in),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .pattern_err (pattern_err),
        .seq_err     (seq_err),
        .dp_err      (dp_err),
        .digit_count (digit_count),
        .err_count   (err_count)
    );

    always #5 CLOCK = ~CLOCK;

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] glyphs [0:10];
    logic [8:0] hist [$];

    logic [3:0]  e_digit;
    logic        e_valid, e_pat, e_seq, e_dp;
    logic [15:0] e_dcount;
    logic [7:0]  e_ecount;
    int          m_prev;
    logic        m_prev_dp;
    logic        m_have_prev;

    function automatic int ref_decode(input logic [6:0] segs);
        for (int i = 0; i < 10; i++) if (glyphs[i] == segs) return i;
        if (glyphs[10] == segs) return 14;
        return 15;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A glyph is accepted when it occupied exactly the last S edges and differed just before.
    task automatic model_edge(input logic [7:0] v, input logic r);
        int n;
        logic [8:0] g;
        logic fire;
        int c;
        e_valid = 0; e_pat = 0; e_seq = 0; e_dp = 0;
        if (r) begin
            hist.push_back(9'h100);
            e_digit = 0; e_dcount = 0; e_ecount = 0;
            m_prev = 0; m_prev_dp = 0; m_have_prev = 0;
            return;
        end
        hist.push_back({1'b0, v});
        n = hist.size();
        fire = 1'b0;
        if (n >= S + 2) begin
            g = hist[n-2];
            fire = !g[8];
            for (int i = 1; i <= S; i++) if (hist[n-1-i] != g) fire = 1'b0;
            if (hist[n-2-S] == g) fire = 1'b0;
        end
        if (fire) begin
            c = ref_decode(g[6:0]);
            e_valid = 1;
            e_digit = 4'(c);
            e_pat   = (c == 15);
            e_seq   = m_have_prev && m_prev < 10 && c < 10 && c != (m_prev + 1) % 10;
            e_dp    = m_have_prev && (g[7] == m_prev_dp);
            if (c < 10 && e_dcount != 16'hFFFF) e_dcount = e_dcount + 1;
            if ((e_pat || e_seq || e_dp) && e_ecount != 8'hFF) e_ecount = e_ecount + 1;
            m_prev = c; m_prev_dp = g[7]; m_have_prev = 1;
        end
    endtask

    task automatic tick(input logic [7:0] v, input logic r);
        seg_in = v;
        RESET  = r;
        @(posedge CLOCK);
        model_edge(v, r);
        #1;
        chk("digit_out",   32'(digit_out),   32'(e_digit));
        chk("digit_valid", 32'(digit_valid), 32'(e_valid));
        chk("pattern_err", 32'(pattern_err), 32'(e_pat));
        chk("seq_err",     32'(seq_err),     32'(e_seq));
        chk("dp_err",      32'(dp_err),      32'(e_dp));
        chk("digit_count", 32'(digit_count), 32'(e_dcount));
        chk("err_count",   32'(err_count),   32'(e_ecount));
    endtask

    task automatic hold(input logic [7:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) tick(v, 1'b0);
    endtask

    int valid_seen;

    initial begin
        glyphs[0] = 7'h3F; glyphs[1] = 7'h06; glyphs[2] = 7'h5B; glyphs[3] = 7'h4F;
        glyphs[4] = 7'h66; glyphs[5] = 7'h6D; glyphs[6] = 7'h7D; glyphs[7] = 7'h07;
        glyphs[8] = 7'h7F; glyphs[9] = 7'h6F; glyphs[10] = 7'h79;

        tick(8'h00, 1'b1);
        tick(8'h00, 1'b1);

        hold(8'h3F, 10);
        chk("t1_count", 32'(digit_count), 32'd1);

        hold(8'h3F, 6); hold(8'h86, 6); hold(8'h5B, 6); hold(8'hCF, 6);
        chk("t2_count", 32'(digit_count), 32'd4);
        chk("t2_errs",  32'(err_count),   32'd0);

        hold(8'hED, 6);
        chk("t3_errs", 32'(err_count), 32'd1);

        valid_seen = 0;
        for (int i = 0; i < 3; i++) begin tick(8'h6F, 1'b0); valid_seen += int'(digit_valid); end
        tick(8'h00, 1'b0); valid_seen += int'(digit_valid);
        for (int i = 0; i < 5; i++) begin tick(8'h6F, 1'b0); valid_seen += int'(digit_valid); end
        chk("t4_accepts", 32'(valid_seen), 32'd1);
        chk("t4_digit",   32'(digit_out),  32'd9);

        hold(8'h12, 5);
        chk("t5_illegal", 32'(digit_out), 32'hF);
        hold(8'h79, 6);
        chk("t5_e_glyph", 32'(digit_out), 32'hE);

        tick(8'h66, 1'b0); tick(8'h66, 1'b0);
        tick(8'h66, 1'b1); tick(8'h66, 1'b1);
        hold(8'h66, 6);
        chk("t6_digit", 32'(digit_out), 32'd4);
        chk("t6_count", 32'(digit_count), 32'd1);

        for (int it = 0; it < 250; it++) begin
            int kind;
            int len;
            logic [7:0] v;
            kind = $urandom_range(0, 19);
            len  = $urandom_range(1, 7);
            if (kind == 0) begin
                for (int i = 0; i < $urandom_range(1, 2); i++) tick(8'($urandom), 1'b1);
            end else begin
                if (kind <= 2) v = 8'($urandom);
                else v = {1'($urandom), glyphs[$urandom_range(0, 10)]};
                hold(v, len);
            end
        end
        hold(8'h3F, S + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
